// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the EX-stage iterative multiply/divide unit.
package muldiv_pkg;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam int MULDIV_ITERS = 32;

   // Quotient reported when the divisor is zero.
   localparam logic [MULDIV_ITERS-1:0] DIV0_QUOTIENT = '1;

   function automatic logic op_is_signed(input logic [1:0] op);
      return (op == OP_MULT) || (op == OP_DIV);
   endfunction

   function automatic logic op_is_div(input logic [1:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shift-add multiplier / restoring divider (purely combinational).
module muldiv_step
   import muldiv_pkg::*;
#(
   parameter int WIDTH = MULDIV_ITERS
) (
   input  logic               is_div_i,
   input  logic [2*WIDTH-1:0] acc_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   output logic [2*WIDTH-1:0] acc_o,
   output logic [WIDTH-1:0]   a_o,
   output logic [WIDTH-1:0]   b_o
);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   addend;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] new_rem;
   logic             no_borrow;

   always_comb begin
      addend    = b_i[0] ? {1'b0, a_i} : '0;
      sum       = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + addend;
      // Dividend bits enter the remainder from the MSB of the shifting dividend register.
      rem_sh    = {acc_i[2*WIDTH-1:WIDTH], a_i[WIDTH-1]};
      diff      = rem_sh - {1'b0, b_i};
      // A set top bit of the shifted remainder means it already exceeds any divisor.
      no_borrow = rem_sh[WIDTH] | ~diff[WIDTH];
      new_rem   = no_borrow ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];

      if (is_div_i) begin
         acc_o = {new_rem, acc_i[WIDTH-2:0], no_borrow};
         a_o   = {a_i[WIDTH-2:0], 1'b0};
         b_o   = b_i;
      end else begin
         acc_o = {sum, acc_i[WIDTH-1:1]};
         a_o   = a_i;
         b_o   = {1'b0, b_i[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative MULT/MULTU/DIV/DIVU engine: stalls the front end for the
// whole operation and writes the HI/LO pair once the result is sign-corrected.
module ex_muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = MULDIV_ITERS
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   output logic             stall,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int              CW       = $clog2(WIDTH);
   localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q;
   logic [2*WIDTH-1:0] acc_q, acc_step;
   logic [WIDTH-1:0]   a_q, a_step, b_q, b_step;
   logic [WIDTH-1:0]   rs_raw_q, hi_q, lo_q, hi_d, lo_d;
   logic               is_div_q, neg_q, rem_neg_q, dbz_q;

   logic               sgn;
   logic [WIDTH-1:0]   rs_mag, rt_mag;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quo, rem;

   assign sgn    = op_is_signed(op);
   assign rs_mag = (sgn && rs_val[WIDTH-1]) ? -rs_val : rs_val;
   assign rt_mag = (sgn && rt_val[WIDTH-1]) ? -rt_val : rt_val;

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .is_div_i (is_div_q),
      .acc_i    (acc_q),
      .a_i      (a_q),
      .b_i      (b_q),
      .acc_o    (acc_step),
      .a_o      (a_step),
      .b_o      (b_step)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start) state_d = ST_RUN;
         ST_RUN:  if (cnt_q == CNT_LAST) state_d = ST_FIX;
         ST_FIX:  state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Sign correction; the overflow case falls out naturally (-0x80000000 wraps to itself).
   always_comb begin
      prod = neg_q ? -acc_q : acc_q;
      quo  = acc_q[WIDTH-1:0];
      rem  = acc_q[2*WIDTH-1:WIDTH];
      hi_d = prod[2*WIDTH-1:WIDTH];
      lo_d = prod[WIDTH-1:0];
      if (is_div_q) begin
         if (dbz_q) begin
            hi_d = rs_raw_q;
            lo_d = DIV0_QUOTIENT;
         end else begin
            hi_d = rem_neg_q ? -rem : rem;
            lo_d = neg_q ? -quo : quo;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         a_q       <= '0;
         b_q       <= '0;
         rs_raw_q  <= '0;
         is_div_q  <= 1'b0;
         neg_q     <= 1'b0;
         rem_neg_q <= 1'b0;
         dbz_q     <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  acc_q     <= '0;
                  cnt_q     <= '0;
                  a_q       <= rs_mag;
                  b_q       <= rt_mag;
                  rs_raw_q  <= rs_val;
                  is_div_q  <= op_is_div(op);
                  neg_q     <= sgn && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                  rem_neg_q <= sgn && rs_val[WIDTH-1];
                  dbz_q     <= op_is_div(op) && (rt_val == '0);
               end
            end
            ST_RUN: begin
               acc_q <= acc_step;
               a_q   <= a_step;
               b_q   <= b_step;
               cnt_q <= cnt_q + CW'(1);
            end
            ST_FIX: begin
               hi_q <= hi_d;
               lo_q <= lo_d;
            end
            default: ;
         endcase
      end
   end

   assign stall = ((state_q == ST_IDLE) && start) || (state_q == ST_RUN) || (state_q == ST_FIX);
   assign busy  = (state_q == ST_RUN) || (state_q == ST_FIX);
   assign done  = (state_q == ST_DONE);
   assign hi    = hi_q;
   assign lo    = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: issue tasks push expected {hi,lo}, a monitor pops on done.
module tb_ex_muldiv_unit;

   localparam logic [1:0] T_MULT  = 2'b00;
   localparam logic [1:0] T_MULTU = 2'b01;
   localparam logic [1:0] T_DIV   = 2'b10;
   localparam logic [1:0] T_DIVU  = 2'b11;

   logic        clk    = 1'b0;
   logic        rst    = 1'b1;
   logic        start  = 1'b0;
   logic [1:0]  op     = 2'b00;
   logic [31:0] rs_val = '0;
   logic [31:0] rt_val = '0;
   logic        stall, busy, done;
   logic [31:0] hi, lo;

   int checks   = 0;
   int failures = 0;
   int ndone    = 0;
   logic [63:0] exp_q[$];
   logic [63:0] prev_res = '0;

   ex_muldiv_unit #(.WIDTH(32)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op     (op),
      .rs_val (rs_val),
      .rt_val (rt_val),
      .stall  (stall),
      .busy   (busy),
      .done   (done),
      .hi     (hi),
      .lo     (lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
      end
   endtask

   // Reference: plain integer arithmetic; returns {hi, lo}.
   function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] r;
      longint la, lb;
      int ia, ib, q, m;
      logic [31:0] qv, mv;
      ia = a;
      ib = b;
      la = ia;
      lb = ib;
      r  = '0;
      case (o)
         T_MULT:  r = la * lb;
         T_MULTU: r = {32'd0, a} * {32'd0, b};
         T_DIV: begin
            if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
            else begin
               q  = ia / ib;
               m  = ia % ib;
               qv = q;
               mv = m;
               r  = {mv, qv};
            end
         end
         default: begin
            if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
            else r = {a % b, a / b};
         end
      endcase
      return r;
   endfunction

   // Monitor: every done pulse must match the oldest outstanding expectation.
   initial begin
      logic [63:0] e;
      forever begin
         @(negedge clk);
         if (done === 1'b1) begin
            ndone++;
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_done: got done=1 with hi=%08h lo=%08h, required no pulse", hi, lo);
            end else begin
               e = exp_q.pop_front();
               check("hi_lo", {hi, lo}, e);
            end
         end
      end
   end

   // Called 1 time unit after a rising edge with the unit idle; returns the same way.
   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] e, input string tag);
      int stalls, busys;
      bit seen;
      start  = 1'b1;
      op     = o;
      rs_val = a;
      rt_val = b;
      exp_q.push_back(e);
      stalls = 0;
      busys  = 0;
      seen   = 1'b0;
      for (int c = 0; c < 80; c++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            seen = 1'b1;
            break;
         end
         if (stall === 1'b1) stalls++;
         if (busy === 1'b1) busys++;
         if (c == 33) check({tag, "_hold"}, {hi, lo}, prev_res);
         @(posedge clk);
         #1;
         if (c == 0) begin
            op     = 2'($urandom);
            rs_val = $urandom;
            rt_val = $urandom;
         end
      end
      check({tag, "_done_seen"}, 64'(seen), 64'd1);
      check({tag, "_stalls"}, 64'(stalls), 64'd34);
      check({tag, "_busy"}, 64'(busys), 64'd33);
      prev_res = e;
      @(posedge clk);
      #1;
      start = 1'b0;
      $display("%s op=%0d a=%08h b=%08h exp_hi=%08h exp_lo=%08h stalls=%0d",
               tag, o, a, b, e[63:32], e[31:0], stalls);
   endtask

   task automatic idle(input int n);
      start = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check("idle_stall", 64'(stall), 64'd0);
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int nd0, m;
      logic [1:0]  ro;
      logic [31:0] ra, rb;

      #2;
      check("reset_hi_lo", {hi, lo}, 64'd0);
      check("reset_flags", {61'd0, busy, done, stall}, 64'd0);
      #20;
      rst = 1'b0;
      @(posedge clk);
      #1;

      issue(T_MULT,  32'hFFFF_FFFD, 32'd7,        {32'hFFFF_FFFF, 32'hFFFF_FFEB}, "mult_neg");
      issue(T_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001}, "multu_max");
      issue(T_DIV,   32'hFFFF_FFF9, 32'd2,        {32'hFFFF_FFFF, 32'hFFFF_FFFD}, "div_neg");
      issue(T_DIV,   32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000}, "div_ovf");
      issue(T_DIVU,  32'd100,       32'd0,        {32'h0000_0064, 32'hFFFF_FFFF}, "divu_zero");
      idle(2);

      // Reset in the middle of RUN (counter at 10): no write, no done pulse.
      nd0    = ndone;
      start  = 1'b1;
      op     = T_MULTU;
      rs_val = 32'h1234_5678;
      rt_val = 32'h9ABC_DEF0;
      repeat (11) @(posedge clk);
      #2;
      start = 1'b0;
      rst   = 1'b1;
      #1;
      check("midrun_rst_hi_lo", {hi, lo}, 64'd0);
      check("midrun_rst_busy_stall", {62'd0, busy, stall}, 64'd0);
      @(posedge clk);
      #2;
      rst = 1'b0;
      @(posedge clk);
      #1;
      prev_res = '0;
      idle(40);
      check("midrun_rst_no_done", 64'(ndone - nd0), 64'd0);
      $display("reset_midrun hi=%08h lo=%08h", hi, lo);

      issue(T_MULTU, 32'd6, 32'd7, {32'd0, 32'd42}, "multu_after_rst");

      // Back-to-back: second op presented in the IDLE cycle right after DONE.
      nd0 = ndone;
      issue(T_DIVU,  32'd9, 32'd4, {32'd1, 32'd2},  "b2b_divu");
      issue(T_MULTU, 32'd3, 32'd5, {32'd0, 32'd15}, "b2b_multu");
      idle(2);
      check("b2b_done_pulses", 64'(ndone - nd0), 64'd2);

      for (int t = 0; t < 30; t++) begin
         ro = 2'($urandom_range(0, 3));
         m  = $urandom_range(0, 7);
         ra = $urandom;
         rb = $urandom;
         case (m)
            0: rb = 32'd0;
            1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            2: begin ra = $urandom_range(0, 100); rb = 32'($urandom_range(1, 9)) * 32'hFFFF_FFFF; end
            3: rb = $urandom_range(1, 16);
            default: ;
         endcase
         issue(ro, ra, rb, ref_model(ro, ra, rb), "rnd");
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end

      idle(3);
      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
